// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv loop sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  localparam int CONV_H_W    = 6;
  localparam int CONV_CH_W   = 7;
  localparam int CONV_HK_W   = 3;
  localparam int CONV_ADDR_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic STRIDE_1 = 1'b0;
  localparam logic STRIDE_2 = 1'b1;
  localparam logic PAD_OFF  = 1'b0;
  localparam logic PAD_SAME = 1'b1;

  // Output extent along one axis: ((n + 2p - k) >> s2) + 1.
  function automatic logic [15:0] out_dim(input logic [15:0] n, input logic [15:0] k,
                                          input logic [15:0] p, input logic s2);
    logic [15:0] span;
    span = n + p + p - k;
    return (span >> s2) + 16'd1;
  endfunction

endpackage

// File: rtl/conv_loop_ctr.sv
// One loop level: counts 0..limit, wraps to 0 and passes a carry to the next level.
// Latency: count is registered; carry-out is combinational from count and carry-in.
// Backpressure: advances only when step and carry-in are both high, otherwise holds.
module conv_loop_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         step,
  input  logic         cin,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         cout
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  assign wrap = (cnt_q == limit);
  assign cout = cin & wrap;
  assign cnt  = cnt_q;

  // Next count: clear, hold, increment or wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step && cin) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Walks k,oy,ox,c,ky,kx for one conv layer and emits one address beat per MAC.
// Latency: first beat valid 2 cycles after start; then one beat per accepted cycle.
// Backpressure: beat fields held while m_valid & !m_ready; en=0 freezes everything.
module conv_loop_sequencer #(
  parameter int H_W    = conv_pkg::CONV_H_W,
  parameter int CH_W   = conv_pkg::CONV_CH_W,
  parameter int HK_W   = conv_pkg::CONV_HK_W,
  parameter int ADDR_W = conv_pkg::CONV_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [H_W-1:0]    H,
  input  logic [H_W-1:0]    W,
  input  logic [CH_W-1:0]   C,
  input  logic [CH_W-1:0]   K,
  input  logic [HK_W-1:0]   hk,
  input  logic              stride2,
  input  logic              pad_en,
  output logic              busy,
  output logic              cfg_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              pad_zero,
  output logic              acc_first,
  output logic              acc_last,
  output logic              done
);
  import conv_pkg::*;

  // Signed tap coordinate width: holds 2*(2^H_W-1) + hk and a small negative.
  localparam int IW = H_W + 3;

  state_e            state_q, state_d;
  logic [H_W-1:0]    h_q, h_d, w_q, w_d, ho_q, ho_d, wo_q, wo_d;
  logic [CH_W-1:0]   c_q, c_d, k_q, k_d;
  logic [HK_W-1:0]   hk_q, hk_d, p_w;
  logic              s2_q, s2_d, pad_q, pad_d, cfg_err_q, cfg_err_d;
  logic [ADDR_W-1:0] hw_q, hw_d, hk2_q, hk2_d, howo_q, howo_d;

  logic [H_W-1:0]    ho_c, wo_c;
  logic [15:0]       h_span, w_span;
  logic              cfg_bad, run, hs, clr;
  logic [5:0]        carry_v;
  logic [HK_W-1:0]   kx_cnt, ky_cnt;
  logic [CH_W-1:0]   c_cnt, k_cnt;
  logic [H_W-1:0]    ox_cnt, oy_cnt;
  logic [IW-1:0]     iy_u, ix_u;
  logic              iy_out, ix_out, pz_c;
  logic [ADDR_W-1:0] act_c, wgt_c, out_c;

  // Geometry derived from the latched config, consumed in SETUP.
  assign p_w     = (pad_q == PAD_SAME) ? ((hk_q - 1'b1) >> 1) : '0;
  assign h_span  = 16'(h_q) + 16'(p_w) + 16'(p_w);
  assign w_span  = 16'(w_q) + 16'(p_w) + 16'(p_w);
  assign ho_c    = H_W'(out_dim(16'(h_q), 16'(hk_q), 16'(p_w), s2_q));
  assign wo_c    = H_W'(out_dim(16'(w_q), 16'(hk_q), 16'(p_w), s2_q));
  assign cfg_bad = ~hk_q[0] | (h_q == '0) | (w_q == '0) | (c_q == '0) | (k_q == '0) |
                   (h_span < 16'(hk_q)) | (w_span < 16'(hk_q));

  assign run = (state_q == ST_RUN);
  assign hs  = en & run & m_ready;
  assign clr = en & (state_q == ST_SETUP);

  // Loop nest, innermost first; each level's carry-in is the wrap of all inner levels.
  conv_loop_ctr #(.W(HK_W)) u_kx (.clk(clk), .rst_n(rst_n), .clr(clr), .step(hs), .cin(1'b1),
    .limit(hk_q - 1'b1), .cnt(kx_cnt), .cout(carry_v[0]));
  conv_loop_ctr #(.W(HK_W)) u_ky (.clk(clk), .rst_n(rst_n), .clr(clr), .step(hs), .cin(carry_v[0]),
    .limit(hk_q - 1'b1), .cnt(ky_cnt), .cout(carry_v[1]));
  conv_loop_ctr #(.W(CH_W)) u_c  (.clk(clk), .rst_n(rst_n), .clr(clr), .step(hs), .cin(carry_v[1]),
    .limit(c_q - 1'b1), .cnt(c_cnt), .cout(carry_v[2]));
  conv_loop_ctr #(.W(H_W))  u_ox (.clk(clk), .rst_n(rst_n), .clr(clr), .step(hs), .cin(carry_v[2]),
    .limit(wo_q - 1'b1), .cnt(ox_cnt), .cout(carry_v[3]));
  conv_loop_ctr #(.W(H_W))  u_oy (.clk(clk), .rst_n(rst_n), .clr(clr), .step(hs), .cin(carry_v[3]),
    .limit(ho_q - 1'b1), .cnt(oy_cnt), .cout(carry_v[4]));
  conv_loop_ctr #(.W(CH_W)) u_k  (.clk(clk), .rst_n(rst_n), .clr(clr), .step(hs), .cin(carry_v[4]),
    .limit(k_q - 1'b1), .cnt(k_cnt), .cout(carry_v[5]));

  // Tap coordinates in two's complement; a set MSB means the tap is above/left of the plane.
  assign iy_u   = (IW'(oy_cnt) << s2_q) + IW'(ky_cnt) - IW'(p_w);
  assign ix_u   = (IW'(ox_cnt) << s2_q) + IW'(kx_cnt) - IW'(p_w);
  assign iy_out = iy_u[IW-1] | (iy_u >= IW'(h_q));
  assign ix_out = ix_u[IW-1] | (ix_u >= IW'(w_q));
  assign pz_c   = iy_out | ix_out;

  assign act_c = ADDR_W'(c_cnt) * hw_q + ADDR_W'(iy_u[H_W-1:0]) * ADDR_W'(w_q)
               + ADDR_W'(ix_u[H_W-1:0]);
  assign wgt_c = ADDR_W'(k_cnt) * ADDR_W'(c_q) * hk2_q + ADDR_W'(c_cnt) * hk2_q
               + ADDR_W'(ky_cnt) * ADDR_W'(hk_q) + ADDR_W'(kx_cnt);
  assign out_c = ADDR_W'(k_cnt) * howo_q + ADDR_W'(oy_cnt) * ADDR_W'(wo_q) + ADDR_W'(ox_cnt);

  // Beat fields are forced to zero outside RUN so reset and idle present all-zero outputs.
  assign busy      = (state_q != ST_IDLE);
  assign cfg_err   = cfg_err_q;
  assign m_valid   = run;
  assign done      = (state_q == ST_DONE);
  assign pad_zero  = run & pz_c;
  assign act_addr  = (run && !pz_c) ? act_c : '0;
  assign wgt_addr  = run ? wgt_c : '0;
  assign out_addr  = run ? out_c : '0;
  assign acc_first = run & (c_cnt == '0) & (ky_cnt == '0) & (kx_cnt == '0);
  assign acc_last  = run & carry_v[2];

  // Next state: latch config on start, derive geometry in SETUP, finish on the last handshake.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    w_d       = w_q;
    c_d       = c_q;
    k_d       = k_q;
    hk_d      = hk_q;
    s2_d      = s2_q;
    pad_d     = pad_q;
    cfg_err_d = cfg_err_q;
    ho_d      = ho_q;
    wo_d      = wo_q;
    hw_d      = hw_q;
    hk2_d     = hk2_q;
    howo_d    = howo_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            h_d       = H;
            w_d       = W;
            c_d       = C;
            k_d       = K;
            hk_d      = hk;
            s2_d      = stride2;
            pad_d     = pad_en;
            cfg_err_d = 1'b0;
            state_d   = ST_SETUP;
          end
        end
        ST_SETUP: begin
          ho_d   = ho_c;
          wo_d   = wo_c;
          hw_d   = ADDR_W'(h_q) * ADDR_W'(w_q);
          hk2_d  = ADDR_W'(hk_q) * ADDR_W'(hk_q);
          howo_d = ADDR_W'(ho_c) * ADDR_W'(wo_c);
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_RUN;
          end
        end
        ST_RUN:  if (hs && carry_v[5]) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and config registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      w_q       <= '0;
      c_q       <= '0;
      k_q       <= '0;
      hk_q      <= '0;
      s2_q      <= STRIDE_1;
      pad_q     <= PAD_OFF;
      cfg_err_q <= 1'b0;
      ho_q      <= '0;
      wo_q      <= '0;
      hw_q      <= '0;
      hk2_q     <= '0;
      howo_q    <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      w_q       <= w_d;
      c_q       <= c_d;
      k_q       <= k_d;
      hk_q      <= hk_d;
      s2_q      <= s2_d;
      pad_q     <= pad_d;
      cfg_err_q <= cfg_err_d;
      ho_q      <= ho_d;
      wo_q      <= wo_d;
      hw_q      <= hw_d;
      hk2_q     <= hk2_d;
      howo_q    <= howo_d;
    end
  end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Bench for conv_loop_sequencer: config table, hand-written corner sequences, random stalls.
// Latency: n/a.
// Backpressure: drives random m_ready/en and checks beat stability.
module tb_conv_loop_sequencer;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, start, stride2, pad_en, m_ready;
  logic [5:0]  H, W;
  logic [6:0]  C, K;
  logic [2:0]  hk;
  logic        busy, cfg_err, m_valid, pad_zero, acc_first, acc_last, done;
  logic [19:0] act_addr, wgt_addr, out_addr;

  conv_loop_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .H(H), .W(W), .C(C), .K(K),
    .hk(hk), .stride2(stride2), .pad_en(pad_en), .busy(busy), .cfg_err(cfg_err),
    .m_valid(m_valid), .m_ready(m_ready), .act_addr(act_addr), .wgt_addr(wgt_addr),
    .out_addr(out_addr), .pad_zero(pad_zero), .acc_first(acc_first), .acc_last(acc_last),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, w, c, k, hk, s2, pad;
    int exp_beats;
    bit exp_err;
  } vec_t;

  typedef struct packed {
    logic [19:0] act, wgt, out;
    logic        pz, af, al;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  vec_t  tbl[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_beat(input string name, input int idx, input beat_t got, input beat_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s beat %0d got act=%0d wgt=%0d out=%0d pz=%b f=%b l=%b exp act=%0d wgt=%0d out=%0d pz=%b f=%b l=%b",
               name, idx, got.act, got.wgt, got.out, got.pz, got.af, got.al,
               exp.act, exp.wgt, exp.out, exp.pz, exp.af, exp.al);
    end
  endtask

  // Reference: enumerate the layer with plain nested loops and integer arithmetic.
  task automatic build_model(input vec_t v, output bit err);
    int p, st, ho, wo, iy, ix;
    beat_t b;
    exp_q.delete();
    p   = v.pad ? (v.hk - 1) / 2 : 0;
    st  = v.s2 ? 2 : 1;
    err = (v.hk % 2 == 0) || v.h == 0 || v.w == 0 || v.c == 0 || v.k == 0 ||
          (v.h + 2 * p < v.hk) || (v.w + 2 * p < v.hk);
    if (!err) begin
      ho = (v.h + 2 * p - v.hk) / st + 1;
      wo = (v.w + 2 * p - v.hk) / st + 1;
      for (int k = 0; k < v.k; k++)
        for (int oy = 0; oy < ho; oy++)
          for (int ox = 0; ox < wo; ox++)
            for (int c = 0; c < v.c; c++)
              for (int ky = 0; ky < v.hk; ky++)
                for (int kx = 0; kx < v.hk; kx++) begin
                  iy    = oy * st + ky - p;
                  ix    = ox * st + kx - p;
                  b.pz  = (iy < 0) || (iy >= v.h) || (ix < 0) || (ix >= v.w);
                  b.act = b.pz ? 20'd0 : 20'(c * v.h * v.w + iy * v.w + ix);
                  b.wgt = 20'(((k * v.c + c) * v.hk + ky) * v.hk + kx);
                  b.out = 20'(k * ho * wo + oy * wo + ox);
                  b.af  = (c == 0) && (ky == 0) && (kx == 0);
                  b.al  = (c == v.c - 1) && (ky == v.hk - 1) && (kx == v.hk - 1);
                  exp_q.push_back(b);
                end
    end
  endtask

  function automatic beat_t sample();
    beat_t b;
    b = {act_addr, wgt_addr, out_addr, pad_zero, acc_first, acc_last};
    return b;
  endfunction

  task automatic drive_cfg(input vec_t v);
    H = 6'(v.h); W = 6'(v.w); C = 7'(v.c); K = 7'(v.k);
    hk = 3'(v.hk); stride2 = v.s2[0]; pad_en = v.pad[0];
  endtask

  // Start one layer and scoreboard every handshake; optionally stop after abort_at beats.
  task automatic run_layer(input vec_t v, input bit rnd, input int abort_at,
                           output int nhs, output bit saw_done, output bit merr);
    beat_t cur, held;
    bit    have_hold, expect_done, finished;
    build_model(v, merr);
    got_q.delete();
    @(negedge clk);
    drive_cfg(v);
    start = 1'b1; en = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nhs = 0; saw_done = 1'b0; have_hold = 1'b0; expect_done = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 30000 && !finished; cyc++) begin
      if (rnd) begin
        m_ready = 1'($urandom_range(0, 1));
        en      = ($urandom_range(0, 5) != 0);
      end
      #1;
      cur = sample();
      if (expect_done || done) begin
        chk("done_after_last_beat", done, expect_done);
        saw_done = done;
        finished = 1'b1;
      end else if (!busy) begin
        finished = 1'b1;
      end else begin
        if (have_hold) begin
          chk("stall_valid_held", m_valid, 1'b1);
          chk_beat("stall_fields_held", nhs, cur, held);
        end
        if (m_valid && en && m_ready) begin
          if (nhs < exp_q.size()) chk_beat("beat", nhs, cur, exp_q[nhs]);
          else chk("extra_beat", 64'(nhs), 64'(exp_q.size()));
          got_q.push_back(cur);
          nhs++;
          have_hold = 1'b0;
          if (nhs == exp_q.size()) expect_done = 1'b1;
          if (nhs == abort_at) finished = 1'b1;
        end else if (m_valid) begin
          have_hold = 1'b1;
          held = cur;
        end
        if (!finished) @(negedge clk);
      end
    end
    if (!finished) chk("run_timeout", 64'd1, 64'd0);
    en = 1'b1; m_ready = 1'b1;
  endtask

  initial begin
    int  nhs;
    bit  sd, merr, seen;
    vec_t v;

    //            h  w  c  k hk s2 pad beats err
    tbl[0]  = '{4, 4, 1, 1, 3, 0, 0,  36, 0};
    tbl[1]  = '{4, 4, 1, 1, 3, 0, 1, 144, 0};
    tbl[2]  = '{5, 5, 1, 1, 3, 1, 0,  36, 0};
    tbl[3]  = '{3, 3, 2, 2, 1, 0, 0,  36, 0};
    tbl[4]  = '{6, 6, 1, 1, 5, 1, 1, 225, 0};
    tbl[5]  = '{3, 3, 1, 1, 7, 0, 1, 441, 0};
    tbl[6]  = '{4, 4, 1, 1, 4, 0, 0,   0, 1};
    tbl[7]  = '{4, 4, 0, 1, 3, 0, 0,   0, 1};
    tbl[8]  = '{2, 4, 1, 1, 3, 0, 0,   0, 1};
    tbl[9]  = '{2, 2, 1, 1, 3, 0, 1,  36, 0};
    tbl[10] = '{4, 4, 1, 1, 0, 0, 1,   0, 1};
    tbl[11] = '{5, 3, 1, 2, 3, 1, 0,  36, 0};

    rst_n = 1'b0; en = 1'b0; start = 1'b0; m_ready = 1'b0;
    drive_cfg(tbl[0]);
    #1;
    chk("reset_ctrl", {busy, cfg_err, m_valid, done, pad_zero, acc_first, acc_last}, 0);
    chk("reset_addr", {act_addr, wgt_addr, out_addr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First-beat latency and single-cycle done.
    @(negedge clk);
    drive_cfg(tbl[0]); start = 1'b1; en = 1'b1; m_ready = 1'b1;
    #1 chk("start_cycle_no_valid", m_valid, 1'b0);
    @(negedge clk); start = 1'b0;
    #1 chk("setup_busy", busy, 1'b1);
    chk("setup_no_valid", m_valid, 1'b0);
    @(negedge clk);
    #1 chk("first_valid", m_valid, 1'b1);
    chk("first_act_wgt", {act_addr, wgt_addr}, 0);
    chk("first_acc_first", acc_first, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      seen = done;
    end
    chk("latency_done_seen", seen, 1'b1);
    @(negedge clk); #1;
    chk("done_one_cycle", {done, busy}, 0);

    // Config table.
    for (int i = 0; i < 12; i++) begin
      run_layer(tbl[i], 1'b0, -1, nhs, sd, merr);
      chk($sformatf("tbl%0d_beats", i), 64'(nhs), 64'(tbl[i].exp_beats));
      chk($sformatf("tbl%0d_done", i), sd, !tbl[i].exp_err);
      chk($sformatf("tbl%0d_cfg_err", i), cfg_err, tbl[i].exp_err);
    end

    // Spot beats from hand-worked examples.
    run_layer(tbl[0], 1'b0, -1, nhs, sd, merr);
    if (nhs == 36) begin
      chk("basic_last_act", got_q[35].act, 20'd15);
      chk("basic_last_wgt", got_q[35].wgt, 20'd8);
      chk("basic_last_out", got_q[35].out, 20'd3);
      chk("basic_last_acc_last", got_q[35].al, 1'b1);
    end else chk("basic_beats", 64'(nhs), 64'd36);
    run_layer(tbl[1], 1'b0, -1, nhs, sd, merr);
    if (nhs == 144) begin
      chk("pad_b0", {got_q[0].pz, got_q[0].act}, {1'b1, 20'd0});
      chk("pad_b4", {got_q[4].pz, got_q[4].act}, {1'b0, 20'd0});
    end else chk("pad_beats", 64'(nhs), 64'd144);
    run_layer(tbl[2], 1'b0, -1, nhs, sd, merr);
    if (nhs == 36) chk("stride_b9", {got_q[9].act, got_q[9].out}, {20'd2, 20'd1});
    else chk("stride_beats", 64'(nhs), 64'd36);

    // Error, then a valid start clears the sticky flag.
    run_layer(tbl[6], 1'b0, -1, nhs, sd, merr);
    chk("err_flag_at_start_plus2", cfg_err, 1'b1);
    chk("err_no_beats", 64'(nhs), 64'd0);
    @(negedge clk); #1;
    chk("err_sticky", cfg_err, 1'b1);
    run_layer(tbl[0], 1'b0, -1, nhs, sd, merr);
    chk("err_cleared", cfg_err, 1'b0);

    // Backpressure and enable gaps on the basic config.
    run_layer(tbl[0], 1'b1, -1, nhs, sd, merr);
    chk("bp_handshakes", 64'(nhs), 64'd36);
    chk("bp_done", sd, 1'b1);

    // Asynchronous reset in mid-run, then a clean restart.
    run_layer(tbl[0], 1'b0, 10, nhs, sd, merr);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {busy, cfg_err, m_valid, done, pad_zero, acc_first, acc_last}, 0);
    chk("midrst_addr", {act_addr, wgt_addr, out_addr}, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      seen = seen | done | busy;
    end
    chk("midrst_quiet", seen, 1'b0);
    run_layer(tbl[0], 1'b0, -1, nhs, sd, merr);
    chk("restart_beats", 64'(nhs), 64'd36);
    chk("restart_done", sd, 1'b1);

    // Random small layers under random stalls.
    for (int r = 0; r < 6; r++) begin
      v.h = $urandom_range(1, 5); v.w = $urandom_range(1, 5);
      v.c = $urandom_range(1, 2); v.k = 1;
      v.hk = 2 * $urandom_range(0, 2) + 1;
      v.s2 = $urandom_range(0, 1); v.pad = $urandom_range(0, 1);
      v.exp_beats = 0; v.exp_err = 1'b0;
      run_layer(v, 1'b1, -1, nhs, sd, merr);
      chk($sformatf("rnd%0d_beats", r), 64'(nhs), 64'(exp_q.size()));
      chk($sformatf("rnd%0d_done", r), sd, !merr);
      chk($sformatf("rnd%0d_cfg_err", r), cfg_err, merr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_loop_sequencer.md
Name: conv_loop_sequencer

Overview:
- Parametrised loop/address sequencer for the convolution core.
- Walks the full nested loop of one conv layer (K, Ho, Wo, C, ky, kx) and emits one beat per MAC.
- Each beat carries the feature-map address, the weight address, the output address, a zero-pad flag and accumulate first/last marks.
- Generalises the fixed 3x3/stride-1 flow with runtime stride (1/2), zero padding, odd kernels up to 7, and valid/ready backpressure to the MAC array.

Parameters:
- H_W, 6, width of the H and W config fields
- CH_W, 7, width of the C and K config fields
- HK_W, 3, width of the hk config field (odd kernel 1..7)
- ADDR_W, 20, width of act_addr, wgt_addr and out_addr

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; 0 freezes all state, outputs hold
- start  in  1  pulse; sampled only in IDLE
- H  in  H_W  input height
- W  in  H_W  input width
- C  in  CH_W  input channels
- K  in  CH_W  output channels
- hk  in  HK_W  kernel size (square)
- stride2  in  1  0 = stride 1, 1 = stride 2
- pad_en  in  1  1 = pad by (hk-1)/2 on every side
- busy  out  1  high outside IDLE
- cfg_err  out  1  sticky invalid-config flag, cleared on next accepted start
- m_valid  out  1  beat valid
- m_ready  in  1  downstream accept
- act_addr  out  ADDR_W  c*H*W + iy*W + ix; 0 when pad_zero
- wgt_addr  out  ADDR_W  ((k*C + c)*hk + ky)*hk + kx
- out_addr  out  ADDR_W  k*Ho*Wo + oy*Wo + ox
- pad_zero  out  1  tap lies outside the input plane; MAC uses 0
- acc_first  out  1  c=ky=kx=0
- acc_last  out  1  c=C-1, ky=kx=hk-1
- done  out  1  one-cycle pulse after the final beat handshake

Behaviour:
- Reset: FSM to IDLE; all outputs 0, including cfg_err. Reset is asynchronous and may arrive mid-run: it discards the layer immediately with no done pulse.
- en=0: FSM, counters and all outputs hold; a handshake only counts when en=1 and m_valid=1 and m_ready=1.
- FSM states: IDLE, SETUP, RUN, DONE.
- IDLE, start=1:
  - Latch all config fields and clear cfg_err.
  - Go to SETUP. start is ignored in every other state.
- SETUP (1 cycle):
  - p = pad_en ? (hk-1)>>1 : 0.
  - Ho = ((H+2p-hk) >> stride2) + 1; Wo computed the same way from W.
  - Precompute H*W, hk*hk and Ho*Wo.
  - Error checks: hk even, hk=0, H/W/C/K = 0, H+2p<hk, or W+2p<hk. On error, set cfg_err and go to IDLE with no beats and no done. Otherwise go to RUN.
- First beat: m_valid rises 2 cycles after the start cycle.
- RUN loop order, outermost to innermost: k, oy, ox, c, ky, kx.
  - Each handshake advances kx and carries into ky, c, ox, oy, k.
  - iy = oy*(stride2?2:1) + ky - p; ix is computed the same way from ox and kx. Both use signed arithmetic.
  - pad_zero = (iy<0) | (iy>=H) | (ix<0) | (ix>=W).
- Backpressure: while m_valid=1 and m_ready=0, every m_* field is held stable; m_valid never drops without a handshake.
- Throughput: one beat per cycle when m_ready=1. Total beats = K*Ho*Wo*C*hk*hk.
- After the final handshake, go to DONE: done=1 and m_valid=0 for one cycle, then IDLE.
- Address arithmetic is unsigned modulo 2^ADDR_W. Configs that overflow are the caller's responsibility; no error is flagged.

Decomposition:
- Shared package conv_pkg: FSM state enum, pad/stride encodings, width constants, and function out_dim(H, hk, p, stride2).
- Sub-module conv_loop_ctr: one counter with a parametrised limit that generates wrap and carry. Instantiate six of them in a chain (kx, ky, c, ox, oy, k).

Test Plan:
- Basic: H=W=4, C=K=1, hk=3, stride 1, no pad, m_ready=1.
  - 36 beats; first beat act_addr=0, wgt_addr=0, acc_first=1.
  - Last beat act_addr=15, wgt_addr=8, out_addr=3, acc_last=1.
  - done pulses the cycle after the last handshake.
- Padding: same config with pad_en=1.
  - Ho=Wo=4, 144 beats.
  - Beat 0: pad_zero=1, act_addr=0. Beat 4 (ky=kx=1): pad_zero=0, act_addr=0.
- Stride 2: H=W=5, hk=3, stride2=1.
  - Ho=Wo=2; beat 9 (ox=1, ky=kx=0) gives act_addr=2, out_addr=1.
- Backpressure/enable: toggle m_ready randomly and pulse en=0 in the basic config.
  - Beat sequence is identical to the basic run; fields are stable while stalled.
  - Exactly 36 handshakes occur.
- Config error: hk=4.
  - cfg_err=1 two cycles after start; no m_valid and no done.
  - A following valid start clears cfg_err.
- Mid-run reset: assert rst_n=0 at beat 10 of the basic run.
  - All outputs go to 0 asynchronously; no done.
  - A restart reproduces the full 36-beat sequence.
